// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: master-side request/response bundle plus the shared downstream memory port
interface mem_arbiter_if #(
  parameter int M_WIDTH     = 32,
  parameter int NUM_MASTERS = 3
);
  logic [NUM_MASTERS-1:0]         m_req;
  logic [NUM_MASTERS-1:0]         m_we;
  logic [NUM_MASTERS*M_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS*2-1:0]       m_width;
  logic [NUM_MASTERS*M_WIDTH-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]         m_ready;
  logic                           m_err;
  logic [M_WIDTH-1:0]             m_rdata;
  logic [NUM_MASTERS-1:0]         grant;
  logic                           mem_req;
  logic                           mem_we;
  logic [M_WIDTH-1:0]             mem_addr;
  logic [1:0]                     mem_width;
  logic [M_WIDTH-1:0]             mem_wdata;
  logic [M_WIDTH-1:0]             mem_rdata;
  logic                           mem_ready;
  modport slave (
    input  m_req, m_we, m_addr, m_width, m_wdata, mem_rdata, mem_ready,
    output m_ready, m_err, m_rdata, grant, mem_req, mem_we, mem_addr, mem_width, mem_wdata
  );
  modport master (
    output m_req, m_we, m_addr, m_width, m_wdata, mem_rdata, mem_ready,
    input  m_ready, m_err, m_rdata, grant, mem_req, mem_we, mem_addr, mem_width, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port with a per-transaction watchdog
module mem_arbiter #(
  parameter int M_WIDTH        = 32,
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int PW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  localparam int WW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PTR_RST = PW'(NUM_MASTERS - 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, ready_q, ready_d;
  logic [PW-1:0]          last_q, last_d, win;
  logic [WW-1:0]          wd_q, wd_d;
  logic                   err_q, err_d, found;
  logic [M_WIDTH-1:0]     rdata_q, rdata_d;
  int                     idx;
  // first requester scanning upward from the master after the last one served
  always_comb begin
    win = last_q;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(last_q) + k) % NUM_MASTERS;
      if (!found && bus.m_req[idx]) begin
        found = 1'b1;
        win = PW'(idx);
      end
    end
  end
  // next state: arbitrate in IDLE, wait for memory or watchdog in BUSY, pulse ready in RESP
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    wd_d = wd_q;
    ready_d = '0;
    err_d = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = BUSY;
        grant_d = '0;
        grant_d[win] = 1'b1;
        last_d = win;
        wd_d = '0;
      end
      BUSY: if (bus.mem_ready) begin
        state_d = RESP;
        ready_d = grant_q;
        err_d = 1'b0;
        rdata_d = bus.mem_rdata;
      end else if (TIMEOUT_CYCLES != 0 && wd_q == WD_LAST) begin
        state_d = RESP;
        ready_d = grant_q;
        err_d = 1'b1;
        rdata_d = '0;
      end else begin
        wd_d = wd_q + WW'(1);
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end
  // state and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= PTR_RST;
      wd_q <= '0;
      ready_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      wd_q <= wd_d;
      ready_q <= ready_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.m_ready   = ready_q;
  assign bus.m_err     = err_q;
  assign bus.m_rdata   = rdata_q;
  assign bus.grant     = grant_q;
  assign bus.mem_req   = state_q == BUSY;
  assign bus.mem_we    = |grant_q && bus.m_we[last_q];
  assign bus.mem_addr  = |grant_q ? bus.m_addr[int'(last_q)*M_WIDTH +: M_WIDTH] : '0;
  assign bus.mem_width = |grant_q ? bus.m_width[int'(last_q)*2 +: 2] : 2'b00;
  assign bus.mem_wdata = |grant_q ? bus.m_wdata[int'(last_q)*M_WIDTH +: M_WIDTH] : '0;
endmodule
